// File: rtl/sid_pkg.sv
// Shared definitions for the SID read-side blocks.
//   REG_*        : register offsets of the read-only SID registers
//   pot_state_t  : phase of the paddle measurement cycle
package sid_pkg;

  localparam logic [4:0] REG_POTX = 5'h19;
  localparam logic [4:0] REG_POTY = 5'h1A;
  localparam logic [4:0] REG_OSC3 = 5'h1B;
  localparam logic [4:0] REG_ENV3 = 5'h1C;

  typedef enum logic {
    POT_DISCHARGE = 1'b0,
    POT_COUNT     = 1'b1
  } pot_state_t;

endpackage

// File: rtl/sid_pot_axis.sv
// One paddle axis: comparator synchronizer, per-cycle captured flag and the
// POT result register. Timing comes from the shared phase counter in
// sid_readback.
//   CLK, RST, CLKen : clock, sync active-high reset, 1 MHz tick enable
//   state           : current measurement phase
//   phase_cnt       : shared phase counter (tick index within the phase)
//   phase_last      : phase_cnt is at its terminal value
//   cmp             : asynchronous comparator input
//   pot             : measured paddle value
module sid_pot_axis
  import sid_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLKen,
  input  pot_state_t state,
  input  logic [7:0] phase_cnt,
  input  logic       phase_last,
  input  logic       cmp,
  output logic [7:0] pot
);

  logic cmp_p0;
  logic cmp_p1;
  logic captured;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmp_p0   <= 1'b0;
      cmp_p1   <= 1'b0;
      captured <= 1'b0;
      pot      <= 8'h00;
    end else begin
      // stage p0 -> p1: two-flop synchronizer for the async comparator
      cmp_p0 <= cmp;
      cmp_p1 <= cmp_p0;
      if (CLKen) begin
        if (state == POT_DISCHARGE) begin
          if (phase_last) begin
            captured <= 1'b0;
          end
        end else if (phase_last) begin
          // End of count wins over a same-tick comparator edge.
          if (!captured) begin
            pot <= 8'hFF;
          end
        end else if (!captured && cmp_p1) begin
          pot      <= phase_cnt;
          captured <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sid_readback.sv
// SID read side: services CPU reads of POTX/POTY/OSC3/ENV3, returns the
// decaying floating-bus value for every other address, and runs the paddle
// discharge/count measurement cycle.
//   CLK, RST, CLKen     : clock, sync active-high reset, 1 MHz tick enable
//   WR, RD, ADDR        : register bus strobes and address
//   DATA_IN             : write data (feeds the floating-bus latch)
//   OSC3, ENV3          : voice 3 values returned on read
//   POTX_CMP, POTY_CMP  : asynchronous paddle comparators
//   POT_DISCH           : high while paddle capacitors are discharged
//   DATA_OUT, RD_ACK    : read data, valid with the one-cycle RD_ACK pulse
module sid_readback
  import sid_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int DECAY_TICKS = 8192,
  parameter int POT_HALF    = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLKen,
  input  logic       WR,
  input  logic       RD,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] OSC3,
  input  logic [7:0] ENV3,
  input  logic       POTX_CMP,
  input  logic       POTY_CMP,
  output logic       POT_DISCH,
  output logic [7:0] DATA_OUT,
  output logic       RD_ACK
);

  localparam int              DECAY_W    = $clog2(DECAY_TICKS + 1);
  localparam logic [DECAY_W-1:0] DECAY_MAX  = DECAY_W'(DECAY_TICKS);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);
  localparam logic [7:0]      PHASE_LAST = 8'(POT_HALF - 1);
  localparam logic [4:0]      ADDR_POTX  = 5'(BASE_ADDR + int'(REG_POTX));
  localparam logic [4:0]      ADDR_POTY  = 5'(BASE_ADDR + int'(REG_POTY));
  localparam logic [4:0]      ADDR_OSC3  = 5'(BASE_ADDR + int'(REG_OSC3));
  localparam logic [4:0]      ADDR_ENV3  = 5'(BASE_ADDR + int'(REG_ENV3));

  function automatic logic [DECAY_W-1:0] decay_sat_inc(input logic [DECAY_W-1:0] v);
    return (v == DECAY_MAX) ? v : v + DECAY_W'(1);
  endfunction

  pot_state_t         state;
  logic [7:0]         phase_cnt;
  logic               phase_last;
  logic               pot_disch;
  logic [7:0]         potx;
  logic [7:0]         poty;
  logic [7:0]         bus_latch;
  logic [DECAY_W-1:0] decay_cnt;
  logic [7:0]         rd_val;
  logic               rd_is_reg;
  logic [7:0]         data_out_p1;
  logic               vld_p1;

  assign phase_last = (phase_cnt == PHASE_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= POT_DISCHARGE;
      phase_cnt <= 8'h00;
      pot_disch <= 1'b1;
    end else if (CLKen) begin
      if (phase_last) begin
        phase_cnt <= 8'h00;
        if (state == POT_DISCHARGE) begin
          state     <= POT_COUNT;
          pot_disch <= 1'b0;
        end else begin
          state     <= POT_DISCHARGE;
          pot_disch <= 1'b1;
        end
      end else begin
        phase_cnt <= phase_cnt + 8'd1;
      end
    end
  end

  sid_pot_axis u_potx (
    .CLK        (CLK),
    .RST        (RST),
    .CLKen      (CLKen),
    .state      (state),
    .phase_cnt  (phase_cnt),
    .phase_last (phase_last),
    .cmp        (POTX_CMP),
    .pot        (potx)
  );

  sid_pot_axis u_poty (
    .CLK        (CLK),
    .RST        (RST),
    .CLKen      (CLKen),
    .state      (state),
    .phase_cnt  (phase_cnt),
    .phase_last (phase_last),
    .cmp        (POTY_CMP),
    .pot        (poty)
  );

  always_comb begin
    rd_val    = bus_latch;
    rd_is_reg = 1'b0;
    case (ADDR)
      ADDR_POTX: begin rd_val = potx; rd_is_reg = 1'b1; end
      ADDR_POTY: begin rd_val = poty; rd_is_reg = 1'b1; end
      ADDR_OSC3: begin rd_val = OSC3; rd_is_reg = 1'b1; end
      ADDR_ENV3: begin rd_val = ENV3; rd_is_reg = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1      <= 1'b0;
      data_out_p1 <= 8'h00;
      bus_latch   <= 8'h00;
      decay_cnt   <= '0;
    end else begin
      // stage p0 -> p1: registered read response
      vld_p1 <= RD;
      if (RD) begin
        data_out_p1 <= rd_val;
      end
      // Old latch value is already in rd_val, so WR may overwrite it freely.
      if (WR) begin
        bus_latch <= DATA_IN;
      end else if (RD && rd_is_reg) begin
        bus_latch <= rd_val;
      end else if (CLKen && !RD && decay_cnt == DECAY_LAST) begin
        bus_latch <= 8'h00;
      end
      if (WR || RD) begin
        decay_cnt <= '0;
      end else if (CLKen) begin
        decay_cnt <= decay_sat_inc(decay_cnt);
      end
    end
  end

  assign POT_DISCH = pot_disch;
  assign DATA_OUT  = data_out_p1;
  assign RD_ACK    = vld_p1;

endmodule

// File: tb/tb_sid_readback.sv
module tb_sid_readback;

  localparam int DECAY = 8192;
  localparam int HALF  = 256;

  logic       CLK = 1'b0;
  logic       RST, CLKen, WR, RD;
  logic [4:0] ADDR;
  logic [7:0] DATA_IN, OSC3, ENV3;
  logic       POTX_CMP, POTY_CMP;
  logic       POT_DISCH, RD_ACK;
  logic [7:0] DATA_OUT;

  int n_cmp  = 0;
  int n_fail = 0;

  sid_readback #(.BASE_ADDR(0), .DECAY_TICKS(DECAY), .POT_HALF(HALF)) dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .RD(RD), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .OSC3(OSC3), .ENV3(ENV3), .POTX_CMP(POTX_CMP),
    .POTY_CMP(POTY_CMP), .POT_DISCH(POT_DISCH), .DATA_OUT(DATA_OUT), .RD_ACK(RD_ACK)
  );

  always #5 CLK = ~CLK;

  // CLKen: one cycle in three.
  int div = 0;
  initial begin
    CLKen = 1'b0;
    forever begin
      @(negedge CLK);
      div   = (div == 2) ? 0 : div + 1;
      CLKen = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // POT timing is derived from the number of CLKen ticks since reset:
  // even half-periods discharge, odd half-periods count.
  bit          chk_en = 0;
  int unsigned pt;
  int unsigned k;
  int          m_decay;
  bit          capx, capy, sx, sy, in_count, isreg;
  bit          hx[2], hy[2];
  logic [7:0]  m_potx, m_poty, m_latch, m_dout, rv;
  bit          m_ack, m_disch;

  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        pt = 0; capx = 0; capy = 0; hx = '{0, 0}; hy = '{0, 0};
        m_potx = 8'h00; m_poty = 8'h00; m_latch = 8'h00; m_dout = 8'h00;
        m_ack = 0; m_decay = 0; m_disch = 1;
      end else begin
        isreg = 1;
        case (int'(ADDR))
          'h19: rv = m_potx;
          'h1A: rv = m_poty;
          'h1B: rv = OSC3;
          'h1C: rv = ENV3;
          default: begin rv = m_latch; isreg = 0; end
        endcase
        m_ack = RD;
        if (RD) m_dout = rv;
        if (WR) m_latch = DATA_IN;
        else if (RD && isreg) m_latch = rv;
        if (WR || RD) m_decay = 0;
        else if (CLKen && m_decay < DECAY) begin
          m_decay++;
          if (m_decay == DECAY) m_latch = 8'h00;
        end
        sx = hx[1]; hx[1] = hx[0]; hx[0] = POTX_CMP;
        sy = hy[1]; hy[1] = hy[0]; hy[0] = POTY_CMP;
        if (CLKen) begin
          in_count = ((pt / HALF) % 2) == 1;
          k = pt % HALF;
          if (in_count) begin
            if (k == HALF - 1) begin
              if (!capx) m_potx = 8'hFF;
              if (!capy) m_poty = 8'hFF;
            end else begin
              if (!capx && sx) begin m_potx = 8'(k); capx = 1; end
              if (!capy && sy) begin m_poty = 8'(k); capy = 1; end
            end
          end else if (k == HALF - 1) begin
            capx = 0; capy = 0;
          end
          pt++;
        end
        m_disch = ((pt / HALF) % 2) == 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("model DATA_OUT", DATA_OUT, m_dout);
        chk("model RD_ACK", {7'd0, RD_ACK}, {7'd0, m_ack});
        chk("model POT_DISCH", {7'd0, POT_DISCH}, {7'd0, m_disch});
      end
    end
  end

  // ---------------- stimulus helpers (entered/left at negedge) ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (!CLKen) @(posedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DATA_IN = d;
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [4:0] a, input logic [7:0] exp);
    RD = 1'b1; ADDR = a;
    @(negedge CLK);
    RD = 1'b0;
    chk({name, " ack"}, {7'd0, RD_ACK}, 8'h01);
    chk(name, DATA_OUT, exp);
  endtask

  task automatic wait_disch(input logic lvl, input int limit, output int ticks);
    ticks = 0;
    while (POT_DISCH !== lvl && ticks < limit) begin
      wait_ticks(1);
      ticks++;
    end
    if (POT_DISCH !== lvl) chk("POT_DISCH wait timeout", {7'd0, POT_DISCH}, {7'd0, lvl});
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
    int         idle;
  } vec_t;

  vec_t vecs[14];
  int   t;

  initial begin
    RST = 1'b1; WR = 1'b0; RD = 1'b0; ADDR = 5'h00; DATA_IN = 8'h00;
    OSC3 = 8'hA7; ENV3 = 8'h3C; POTX_CMP = 1'b0; POTY_CMP = 1'b0;

    vecs[0]  = '{0, 1, 5'h19, 8'h00, 8'h00, 0};
    vecs[1]  = '{0, 1, 5'h1A, 8'h00, 8'h00, 0};
    vecs[2]  = '{1, 0, 5'h00, 8'h5A, 8'h00, 10};
    vecs[3]  = '{0, 1, 5'h00, 8'h00, 8'h5A, 0};
    vecs[4]  = '{1, 0, 5'h04, 8'h11, 8'h00, 0};
    vecs[5]  = '{1, 1, 5'h05, 8'h33, 8'h11, 0};
    vecs[6]  = '{0, 1, 5'h05, 8'h00, 8'h33, 0};
    vecs[7]  = '{0, 1, 5'h1B, 8'h00, 8'hA7, 0};
    vecs[8]  = '{0, 1, 5'h1C, 8'h00, 8'h3C, 0};
    vecs[9]  = '{0, 1, 5'h00, 8'h00, 8'h3C, 0};
    vecs[10] = '{1, 0, 5'h19, 8'hEE, 8'h00, 0};
    vecs[11] = '{0, 1, 5'h03, 8'h00, 8'hEE, 0};
    vecs[12] = '{0, 1, 5'h19, 8'h00, 8'h00, 0};
    vecs[13] = '{0, 1, 5'h07, 8'h00, 8'h00, 0};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk_en = 1;
    chk("reset DATA_OUT", DATA_OUT, 8'h00);
    chk("reset RD_ACK", {7'd0, RD_ACK}, 8'h00);
    chk("reset POT_DISCH", {7'd0, POT_DISCH}, 8'h01);

    for (int i = 0; i < 14; i++) begin
      WR = vecs[i].wr; RD = vecs[i].rd; ADDR = vecs[i].addr; DATA_IN = vecs[i].din;
      @(negedge CLK);
      WR = 1'b0; RD = 1'b0;
      chk($sformatf("vec%0d ack", i), {7'd0, RD_ACK}, {7'd0, vecs[i].rd});
      if (vecs[i].rd) chk($sformatf("vec%0d data", i), DATA_OUT, vecs[i].exp);
      if (vecs[i].idle > 0) wait_ticks(vecs[i].idle);
    end

    // Paddle measurement: X comparator rises 100 ticks into COUNT, Y stays low.
    wait_disch(1'b0, 600, t);
    wait_ticks(100);
    POTX_CMP = 1'b1;
    t = 100;
    while (POT_DISCH === 1'b0 && t < 400) begin
      wait_ticks(1);
      t++;
    end
    chk("COUNT length", 8'(t), 8'(HALF));
    POTX_CMP = 1'b0;
    bus_read("POTX after count", 5'h19, 8'd100);
    bus_read("POTY uncaptured", 5'h1A, 8'hFF);

    // Reset 50 ticks into COUNT with the X comparator high.
    wait_disch(1'b0, 300, t);
    wait_ticks(50);
    POTX_CMP = 1'b1;
    repeat (2) @(negedge CLK);
    chk("pre-reset POT_DISCH", {7'd0, POT_DISCH}, 8'h00);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("post-reset POT_DISCH", {7'd0, POT_DISCH}, 8'h01);
    bus_read("POTX after reset", 5'h19, 8'h00);
    POTX_CMP = 1'b0;

    // Bus decay boundary: still held one tick short, cleared at the limit.
    bus_write(5'h02, 8'h77);
    wait_ticks(DECAY - 1);
    bus_read("latch before decay", 5'h00, 8'h77);
    wait_ticks(DECAY);
    bus_read("latch after decay", 5'h00, 8'h00);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      WR = ($urandom_range(5) == 0);
      RD = ($urandom_range(2) == 0);
      ADDR = ($urandom_range(1) == 0) ? 5'(25 + $urandom_range(3)) : 5'($urandom_range(31));
      DATA_IN = 8'($urandom);
      if ($urandom_range(7) == 0) OSC3 = 8'($urandom);
      if ($urandom_range(7) == 0) ENV3 = 8'($urandom);
      if ($urandom_range(40) == 0) POTX_CMP = ~POTX_CMP;
      if ($urandom_range(40) == 0) POTY_CMP = ~POTY_CMP;
      RST = ($urandom_range(1499) == 0);
      @(negedge CLK);
    end
    RST = 1'b0; WR = 1'b0; RD = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
